user_motion_ctrl: RTL and testbench

Player-ship motion sequencer. It sits directly upstream of the user sprite plotter. On each frame tick it samples the left/right controls and computes the new clamped ship position. To redraw the ship it runs an erase-then-draw sequence through the plotter's start/done handshake. It also drives the `erase` select, which the top level uses to force plotted pixels to black.

---
 rtl/user_motion_ctrl_if.sv | 25 ++
 rtl/user_motion_ctrl.sv | 116 +++++++++++
 tb/tb_user_motion_ctrl.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/user_motion_ctrl_if.sv
// Handshake and position bundle between the motion sequencer and its
// surroundings (frame timing, player controls, sprite plotter).
interface user_motion_ctrl_if;
    logic       i_frame_tick;
    logic       i_move_left;
    logic       i_move_right;
    logic       i_plot_done;
    logic       o_plot_start;
    logic       o_erase;
    logic [8:0] o_x_pos;
    logic [7:0] o_y_pos;
    logic       o_busy;

    // Sequencer side
    modport master (
        input  i_frame_tick, i_move_left, i_move_right, i_plot_done,
        output o_plot_start, o_erase, o_x_pos, o_y_pos, o_busy
    );

    // Environment side (controls, plotter, frame timing)
    modport slave (
        output i_frame_tick, i_move_left, i_move_right, i_plot_done,
        input  o_plot_start, o_erase, o_x_pos, o_y_pos, o_busy
    );
endinterface

// File: rtl/user_motion_ctrl.sv
// Player-ship motion sequencer: samples left/right on each frame tick and
// redraws the ship via an erase pass at the old x then a draw pass at the
// new, clamped x.
//
// state        | meaning
// -------------+-----------------------------------------------
// INIT         | reset state, leads straight into the first draw
// DRAW_START   | plot_start pulse for the draw pass
// DRAW_WAIT    | waiting for plot_done of the draw pass
// IDLE         | waiting for a frame tick with a legal move
// ERASE_START  | plot_start pulse for the erase pass (erase high)
// ERASE_WAIT   | waiting for plot_done of the erase pass (erase high)
// UPDATE       | x_pos takes its new value
module user_motion_ctrl #(
    parameter int X_INIT = 150,
    parameter int Y_POS  = 220,
    parameter int X_MIN  = 0,
    parameter int X_MAX  = 300,
    parameter int STEP   = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    user_motion_ctrl_if.master    ctrl
);

    localparam logic [9:0] L_X_INIT = 10'(X_INIT);
    localparam logic [9:0] L_X_MIN  = 10'(X_MIN);
    localparam logic [9:0] L_X_MAX  = 10'(X_MAX);
    localparam logic [9:0] L_STEP   = 10'(STEP);
    localparam logic [7:0] L_Y_POS  = 8'(Y_POS);

    typedef enum logic [2:0] {
        S_INIT, S_DRAW_START, S_DRAW_WAIT, S_IDLE,
        S_ERASE_START, S_ERASE_WAIT, S_UPDATE
    } state_t;

    typedef enum logic [1:0] {DIR_NONE, DIR_LEFT, DIR_RIGHT} dir_t;

    state_t     r_state;
    state_t     w_state_nxt;
    dir_t       r_dir_q;
    dir_t       w_dir;
    // Kept at 10 bits so the clamp compares cannot wrap; the top bit is
    // always zero because the result never exceeds X_MAX.
    logic [9:0] r_x_pos;
    logic [9:0] w_x_left;
    logic [9:0] w_x_right;
    logic       w_tick_move;

    // Direction request, qualified so a move never pushes past either edge
    always_comb begin
        w_dir = DIR_NONE;
        if (ctrl.i_move_left && !ctrl.i_move_right && (r_x_pos > L_X_MIN))
            w_dir = DIR_LEFT;
        else if (ctrl.i_move_right && !ctrl.i_move_left && (r_x_pos < L_X_MAX))
            w_dir = DIR_RIGHT;
    end

    assign w_tick_move = ctrl.i_frame_tick && (w_dir != DIR_NONE);

    // Clamped candidate positions for both directions
    always_comb begin
        w_x_left  = (r_x_pos < (L_X_MIN + L_STEP)) ? L_X_MIN : (r_x_pos - L_STEP);
        w_x_right = ((r_x_pos + L_STEP) > L_X_MAX) ? L_X_MAX : (r_x_pos + L_STEP);
    end

    // State register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= S_INIT;
        else         r_state <= w_state_nxt;
    end

    // Next-state logic; ticks and plot_done outside their states are dropped
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_INIT:        w_state_nxt = S_DRAW_START;
            S_DRAW_START:  w_state_nxt = S_DRAW_WAIT;
            S_DRAW_WAIT:   if (ctrl.i_plot_done) w_state_nxt = S_IDLE;
            S_IDLE:        if (w_tick_move) w_state_nxt = S_ERASE_START;
            S_ERASE_START: w_state_nxt = S_ERASE_WAIT;
            S_ERASE_WAIT:  if (ctrl.i_plot_done) w_state_nxt = S_UPDATE;
            S_UPDATE:      w_state_nxt = S_DRAW_START;
            default:       w_state_nxt = S_INIT;
        endcase
    end

    // Direction latch and position update; x only moves in UPDATE so it is
    // stable across every plot pass
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_dir_q <= DIR_NONE;
            r_x_pos <= L_X_INIT;
        end else begin
            if ((r_state == S_IDLE) && w_tick_move)
                r_dir_q <= w_dir;
            if (r_state == S_UPDATE) begin
                case (r_dir_q)
                    DIR_LEFT:  r_x_pos <= w_x_left;
                    DIR_RIGHT: r_x_pos <= w_x_right;
                    default:   r_x_pos <= r_x_pos;
                endcase
            end
        end
    end

    // Moore outputs decoded from the state register only
    always_comb begin
        ctrl.o_plot_start = (r_state == S_ERASE_START) || (r_state == S_DRAW_START);
        ctrl.o_erase      = (r_state == S_ERASE_START) || (r_state == S_ERASE_WAIT);
        ctrl.o_busy       = (r_state != S_IDLE);
        ctrl.o_x_pos      = r_x_pos[8:0];
        ctrl.o_y_pos      = L_Y_POS;
    end

endmodule

// File: tb/tb_user_motion_ctrl.sv
// Bench for user_motion_ctrl. Three instances: unit 0 at X_INIT=150 for the
// general scenarios, units 1 and 2 at X_INIT=151 so the odd positions x=1 and
// x=299 are reachable for the clamp cases. A plotter model answers each
// plot_start with plot_done after lat cycles; a scoreboard holds the
// expected (unit, erase, x) of every plot_start.
module tb_user_motion_ctrl;

    localparam int NU = 3;

    logic           clk;
    logic [NU-1:0]  rst, tick, ml, mr, spur, pd_model;
    wire  [NU-1:0]  ps, er, bz;
    wire  [8:0]     xp [NU];
    wire  [7:0]     yp [NU];

    typedef struct {int u; logic er; logic [8:0] x;} exp_t;
    exp_t sb[$];
    exp_t e;

    int n_vec = 0;
    int n_err = 0;
    int n_starts [NU];
    int cnt [NU];
    int mx [NU];
    int lat;

    for (genvar g = 0; g < NU; g++) begin : g_u
        user_motion_ctrl_if bus();
        assign bus.i_frame_tick = tick[g];
        assign bus.i_move_left  = ml[g];
        assign bus.i_move_right = mr[g];
        assign bus.i_plot_done  = pd_model[g] | spur[g];
        assign ps[g] = bus.o_plot_start;
        assign er[g] = bus.o_erase;
        assign bz[g] = bus.o_busy;
        assign xp[g] = bus.o_x_pos;
        assign yp[g] = bus.o_y_pos;
        user_motion_ctrl #(.X_INIT(g == 0 ? 150 : 151)) dut (
            .i_clk   (clk),
            .i_reset (rst[g]),
            .ctrl    (bus)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Plotter model: plot_done one cycle wide, lat cycles after the start
    always @(posedge clk) begin
        for (int u = 0; u < NU; u++) begin
            pd_model[u] <= 1'b0;
            if (rst[u]) cnt[u] <= 0;
            else if (ps[u]) cnt[u] <= lat;
            else if (cnt[u] > 0) begin
                cnt[u] <= cnt[u] - 1;
                if (cnt[u] == 1) pd_model[u] <= 1'b1;
            end
        end
    end

    // Scoreboard: every plot_start must match the oldest expectation
    always @(negedge clk) begin
        for (int u = 0; u < NU; u++) begin
            if (ps[u] === 1'b1) begin
                n_starts[u]++;
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_start unit=%0d got start erase=%b x=%0d, required no start", u, er[u], xp[u]);
                end else begin
                    e = sb.pop_front();
                    if (e.u != u || er[u] !== e.er || xp[u] !== e.x || yp[u] !== 8'd220) begin
                        n_err++;
                        $display("FAIL plot_start unit=%0d got erase=%b x=%0d y=%0d, required unit=%0d erase=%b x=%0d y=220",
                                 u, er[u], xp[u], yp[u], e.u, e.er, e.x);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic int model_next(input int x, input logic l, input logic r);
        if (l && !r && x > 0)   return (x < 2) ? 0 : x - 2;
        if (r && !l && x < 300) return (x + 2 > 300) ? 300 : x + 2;
        return -1;
    endfunction

    task automatic do_tick(input int u, input logic l, input logic r);
        int nx;
        nx = model_next(mx[u], l, r);
        if (nx >= 0) begin
            sb.push_back('{u, 1'b1, 9'(mx[u])});
            sb.push_back('{u, 1'b0, 9'(nx)});
            mx[u] = nx;
        end
        @(negedge clk);
        ml[u] = l; mr[u] = r; tick[u] = 1'b1;
        @(negedge clk);
        tick[u] = 1'b0;
    endtask

    task automatic wait_idle(input int u, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bz[u] === 1'b0 && sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic walk(input int u, input logic l, input logic r, input int target);
        bit ok;
        for (int i = 0; i < 200 && mx[u] != target; i++) begin
            do_tick(u, l, r);
            wait_idle(u, 200, ok);
            n_vec++;
            if (!ok) begin
                n_err++;
                $display("FAIL walk_timeout unit=%0d got busy=%b x=%0d, required idle", u, bz[u], xp[u]);
                return;
            end
        end
    endtask

    task automatic test_reset();
        bit ok;
        repeat (2) @(negedge clk);
        n_vec++; if (bz[0] !== 1'b1)    begin n_err++; $display("FAIL reset_busy got %b required 1", bz[0]); end
        n_vec++; if (ps[0] !== 1'b0)    begin n_err++; $display("FAIL reset_plot_start got %b required 0", ps[0]); end
        n_vec++; if (er[0] !== 1'b0)    begin n_err++; $display("FAIL reset_erase got %b required 0", er[0]); end
        n_vec++; if (xp[0] !== 9'd150)  begin n_err++; $display("FAIL reset_x got %0d required 150", xp[0]); end
        n_vec++; if (yp[0] !== 8'd220)  begin n_err++; $display("FAIL reset_y got %0d required 220", yp[0]); end
        for (int u = 0; u < NU; u++) sb.push_back('{u, 1'b0, 9'(mx[u])});
        rst = '0;
        for (int u = 0; u < NU; u++) begin
            wait_idle(u, 1000, ok);
            n_vec++; if (!ok) begin n_err++; $display("FAIL init_draw_timeout unit=%0d got busy=%b, required idle", u, bz[u]); end
        end
        n_vec++; if (n_starts[0] != 1) begin n_err++; $display("FAIL init_draw_count got %0d required 1", n_starts[0]); end
        n_vec++; if (xp[0] !== 9'd150) begin n_err++; $display("FAIL init_x got %0d required 150", xp[0]); end
    endtask

    task automatic test_move_right();
        bit ok;
        int s;
        s = n_starts[0];
        do_tick(0, 1'b0, 1'b1);
        n_vec++; if (ps[0] !== 1'b1 || er[0] !== 1'b1) begin n_err++; $display("FAIL erase_start got start=%b erase=%b required 1 1", ps[0], er[0]); end
        @(negedge clk);
        n_vec++; if (ps[0] !== 1'b0 || er[0] !== 1'b1 || bz[0] !== 1'b1) begin n_err++; $display("FAIL erase_wait got start=%b erase=%b busy=%b required 0 1 1", ps[0], er[0], bz[0]); end
        n_vec++; if (xp[0] !== 9'd150) begin n_err++; $display("FAIL erase_x got %0d required 150", xp[0]); end
        wait_idle(0, 200, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL move_right_timeout got busy=%b required idle", bz[0]); end
        n_vec++; if (xp[0] !== 9'd152) begin n_err++; $display("FAIL move_right_x got %0d required 152", xp[0]); end
        n_vec++; if (n_starts[0] - s != 2) begin n_err++; $display("FAIL move_right_starts got %0d required 2", n_starts[0] - s); end
    endtask

    task automatic test_clamp(input int u, input logic l, input logic r, input int pre, input int edge_x);
        bit ok;
        int s;
        walk(u, l, r, pre);
        n_vec++; if (xp[u] !== 9'(pre)) begin n_err++; $display("FAIL pre_clamp_x unit=%0d got %0d required %0d", u, xp[u], pre); end
        do_tick(u, l, r);
        wait_idle(u, 200, ok);
        n_vec++; if (!ok || xp[u] !== 9'(edge_x)) begin n_err++; $display("FAIL clamp_x unit=%0d got %0d required %0d", u, xp[u], edge_x); end
        s = n_starts[u];
        do_tick(u, l, r);
        repeat (4) @(negedge clk);
        n_vec++; if (bz[u] !== 1'b0 || n_starts[u] != s) begin n_err++; $display("FAIL edge_no_move unit=%0d got busy=%b starts=%0d required 0 0", u, bz[u], n_starts[u] - s); end
        n_vec++; if (xp[u] !== 9'(edge_x)) begin n_err++; $display("FAIL edge_hold_x unit=%0d got %0d required %0d", u, xp[u], edge_x); end
        ml[u] = 1'b0; mr[u] = 1'b0;
    endtask

    task automatic test_both_and_drop();
        bit ok;
        int s;
        s = n_starts[0];
        do_tick(0, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        n_vec++; if (bz[0] !== 1'b0 || n_starts[0] != s || xp[0] !== 9'd152) begin n_err++; $display("FAIL both_dirs got busy=%b starts=%0d x=%0d required 0 0 152", bz[0], n_starts[0] - s, xp[0]); end
        do_tick(0, 1'b0, 1'b1);
        tick[0] = 1'b1;
        @(negedge clk);
        tick[0] = 1'b0;
        wait_idle(0, 200, ok);
        repeat (4) @(negedge clk);
        n_vec++; if (!ok || xp[0] !== 9'd154) begin n_err++; $display("FAIL drop_tick_x got %0d required 154", xp[0]); end
        n_vec++; if (n_starts[0] - s != 2) begin n_err++; $display("FAIL drop_tick_starts got %0d required 2", n_starts[0] - s); end
        mr[0] = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        walk(0, 1'b0, 1'b1, 198);
        lat = 20;
        do_tick(0, 1'b0, 1'b1);
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        n_vec++; if (xp[0] !== 9'd200 || bz[0] !== 1'b1) begin n_err++; $display("FAIL draw_wait_pre got x=%0d busy=%b required 200 1", xp[0], bz[0]); end
        rst[0] = 1'b1;
        #1;
        n_vec++; if (bz[0] !== 1'b1 || ps[0] !== 1'b0 || er[0] !== 1'b0) begin n_err++; $display("FAIL async_reset_ctl got busy=%b start=%b erase=%b required 1 0 0", bz[0], ps[0], er[0]); end
        n_vec++; if (xp[0] !== 9'd150) begin n_err++; $display("FAIL async_reset_x got %0d required 150", xp[0]); end
        mx[0] = 150;
        sb.push_back('{0, 1'b0, 9'd150});
        @(negedge clk);
        rst[0] = 1'b0;
        wait_idle(0, 200, ok);
        n_vec++; if (!ok || xp[0] !== 9'd150) begin n_err++; $display("FAIL redraw_after_reset got x=%0d busy=%b required 150 0", xp[0], bz[0]); end
        mr[0] = 1'b0;
        lat = 3;
    endtask

    task automatic test_spurious();
        bit ok;
        int s;
        s = n_starts[0];
        @(negedge clk); spur[0] = 1'b1;
        @(negedge clk); spur[0] = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++; if (bz[0] !== 1'b0 || n_starts[0] != s || xp[0] !== 9'd150) begin n_err++; $display("FAIL spurious_done got busy=%b starts=%0d x=%0d required 0 0 150", bz[0], n_starts[0] - s, xp[0]); end
        lat = 10;
        do_tick(0, 1'b1, 1'b0);
        @(negedge clk);
        ml[0] = 1'b0; mr[0] = 1'b1;
        wait_idle(0, 200, ok);
        n_vec++; if (!ok || xp[0] !== 9'd148) begin n_err++; $display("FAIL mid_seq_toggle got x=%0d required 148", xp[0]); end
        mr[0] = 1'b0;
        lat = 3;
    endtask

    initial begin
        rst = '1; tick = '0; ml = '0; mr = '0; spur = '0;
        lat = 400;
        mx[0] = 150; mx[1] = 151; mx[2] = 151;
        for (int u = 0; u < NU; u++) n_starts[u] = 0;
        test_reset();
        lat = 3;
        test_move_right();
        test_clamp(1, 1'b1, 1'b0, 1, 0);
        test_clamp(2, 1'b0, 1'b1, 299, 300);
        test_both_and_drop();
        test_reset_mid();
        test_spurious();
        repeat (4) @(negedge clk);
        n_vec++; if (sb.size() != 0) begin n_err++; $display("FAIL scoreboard_drain got %0d pending required 0", sb.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
